// File: rtl/decode_execute_seq.sv
// Clocked decode-and-execute unit: register file, single-cycle ALU ops,
// iterative shift-add MUL, and a registered valid/ready result port.
module decode_execute_seq #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned REG_AW = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [REG_AW-1:0] in_rd,
  input  logic [REG_AW-1:0] in_rs,
  input  logic [REG_AW-1:0] in_rt,
  input  logic [WIDTH-1:0]  in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic [REG_AW-1:0] out_rd,
  output logic              out_carry,
  output logic              out_zero,
  output logic              out_err,
  output logic              busy
);

  localparam int unsigned NumRegs = 2 ** REG_AW;
  localparam int unsigned CntW    = $clog2(WIDTH);

  localparam logic [3:0] OpAdd = 4'd0;
  localparam logic [3:0] OpSub = 4'd1;
  localparam logic [3:0] OpAnd = 4'd2;
  localparam logic [3:0] OpOr  = 4'd3;
  localparam logic [3:0] OpRol = 4'd4;
  localparam logic [3:0] OpSra = 4'd5;
  localparam logic [3:0] OpEq  = 4'd6;
  localparam logic [3:0] OpGt  = 4'd7;
  localparam logic [3:0] OpLdi = 4'd8;
  localparam logic [3:0] OpMul = 4'd9;

  typedef enum logic [0:0] {StIdle, StMul} state_e;

  state_e              state_q;
  logic [WIDTH-1:0]    regs_q [NumRegs];
  logic [2*WIDTH-1:0]  mcand_q, acc_q, acc_d;
  logic [WIDTH-1:0]    mplier_q;
  logic [CntW-1:0]     cnt_q;
  logic [REG_AW-1:0]   rd_q;
  logic                out_valid_q, out_carry_q, out_zero_q, out_err_q, busy_q;
  logic [WIDTH-1:0]    out_data_q;
  logic [REG_AW-1:0]   out_rd_q;

  logic                accept, mul_last;
  logic [WIDTH-1:0]    opa, opb;
  logic [WIDTH:0]      add_w, sub_w;
  logic [WIDTH-1:0]    alu_data;
  logic                alu_carry, alu_err, alu_wr;

  assign in_ready = (state_q == StIdle) && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign opa      = regs_q[in_rs];
  assign opb      = regs_q[in_rt];
  assign add_w    = {1'b0, opa} + {1'b0, opb};
  // Two's-complement subtract; carry-out of 1 means no borrow.
  assign sub_w    = {1'b0, opa} + {1'b0, ~opb} + {{WIDTH{1'b0}}, 1'b1};
  // Partial product including the current multiplier bit.
  assign acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign mul_last = (cnt_q == CntW'(WIDTH - 1));

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_rd    = out_rd_q;
  assign out_carry = out_carry_q;
  assign out_zero  = out_zero_q;
  assign out_err   = out_err_q;
  assign busy      = busy_q;

  // Decode the opcode and compute the single-cycle result and flags.
  always_comb begin
    alu_data  = '0;
    alu_carry = 1'b0;
    alu_err   = 1'b0;
    alu_wr    = 1'b1;
    unique case (in_op)
      OpAdd: {alu_carry, alu_data} = add_w;
      OpSub: {alu_carry, alu_data} = sub_w;
      OpAnd: alu_data = opa & opb;
      OpOr:  alu_data = opa | opb;
      OpRol: alu_data = {opa[WIDTH-2:0], opa[WIDTH-1]};
      OpSra: alu_data = {opb[WIDTH-1], opb[WIDTH-1:1]};
      OpEq:  alu_data = {{(WIDTH-1){1'b0}}, opa == opb};
      OpGt:  alu_data = {{(WIDTH-1){1'b0}}, opa > opb};
      OpLdi: alu_data = in_imm;
      OpMul: alu_wr   = 1'b0;
      default: begin
        alu_err = 1'b1;
        alu_wr  = 1'b0;
      end
    endcase
  end

  // Control FSM, register file, multiplier datapath and output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      for (int i = 0; i < NumRegs; i++) regs_q[i] <= '0;
      mcand_q     <= '0;
      acc_q       <= '0;
      mplier_q    <= '0;
      cnt_q       <= '0;
      rd_q        <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_rd_q    <= '0;
      out_carry_q <= 1'b0;
      out_zero_q  <= 1'b0;
      out_err_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept && in_op == OpMul) begin
            // Operands latched here, so rd may alias rs or rt.
            mcand_q     <= {{WIDTH{1'b0}}, opa};
            mplier_q    <= opb;
            acc_q       <= '0;
            cnt_q       <= '0;
            rd_q        <= in_rd;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= StMul;
          end else if (accept) begin
            if (alu_wr) regs_q[in_rd] <= alu_data;
            out_data_q  <= alu_data;
            out_rd_q    <= in_rd;
            out_carry_q <= alu_carry;
            out_zero_q  <= (alu_data == '0);
            out_err_q   <= alu_err;
            out_valid_q <= 1'b1;
          end else if (out_ready) begin
            out_valid_q <= 1'b0;
          end
        end
        StMul: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + CntW'(1);
          if (mul_last) begin
            regs_q[rd_q] <= acc_d[WIDTH-1:0];
            out_data_q   <= acc_d[WIDTH-1:0];
            out_rd_q     <= rd_q;
            out_carry_q  <= (acc_d[2*WIDTH-1:WIDTH] != '0);
            out_zero_q   <= (acc_d[WIDTH-1:0] == '0);
            out_err_q    <= 1'b0;
            out_valid_q  <= 1'b1;
            busy_q       <= 1'b0;
            state_q      <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_decode_execute_seq.sv
// Scoreboard bench for decode_execute_seq: stimulus pushes expected results,
// a negedge monitor pops and compares each transferred result.
module tb_decode_execute_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] in_op = '0;
  logic [2:0] in_rd = '0, in_rs = '0, in_rt = '0;
  logic [7:0] in_imm = '0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] out_data;
  logic [2:0] out_rd;
  logic       out_carry, out_zero, out_err, busy;

  decode_execute_seq #(.WIDTH(8), .REG_AW(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_rd     (in_rd),
    .in_rs     (in_rs),
    .in_rt     (in_rt),
    .in_imm    (in_imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_rd    (out_rd),
    .out_carry (out_carry),
    .out_zero  (out_zero),
    .out_err   (out_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic [2:0] rd;
    logic       carry;
    logic       zero;
    logic       err;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   passed = 0;
  int   total  = 0;
  int   cyc    = 0;
  int   ac, c1, c2;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Monitor: a result transfers on the next rising edge when valid && ready.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && out_valid === 1'b1 && out_ready === 1'b1) begin
        if (sb.size() == 0) begin
          total++;
          $display("FAIL unexpected_result: got data 0x%0h, expected no result", out_data);
        end else begin
          mon_e = sb.pop_front();
          check("out_data",  out_data,  mon_e.data);
          check("out_rd",    out_rd,    mon_e.rd);
          check("out_carry", out_carry, mon_e.carry);
          check("out_zero",  out_zero,  mon_e.zero);
          check("out_err",   out_err,   mon_e.err);
        end
      end
    end
  end

  // Drive one instruction from posedge+1 and hold it until it is accepted.
  task automatic issue(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs,
                       input logic [2:0] rt, input logic [7:0] imm, input logic [7:0] ed,
                       input logic ec, input logic ee, input bit push, output int acc_cyc);
    int n = 0;
    in_op = op; in_rd = rd; in_rs = rs; in_rt = rt; in_imm = imm;
    in_valid = 1'b1;
    if (push) sb.push_back('{ed, rd, ec, (ed == 8'h00), ee});
    while (!in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      total++;
      $display("FAIL issue_timeout: got in_ready 0, expected 1 within 200 cycles");
    end
    @(posedge clk); #1;
    acc_cyc  = cyc;
    in_valid = 1'b0;
  endtask

  task automatic ex(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs,
                    input logic [2:0] rt, input logic [7:0] ed, input logic ec,
                    input logic ee);
    issue(op, rd, rs, rt, 8'h00, ed, ec, ee, 1'b1, ac);
  endtask

  task automatic ldi(input logic [2:0] rd, input logic [7:0] imm);
    issue(4'd8, rd, 3'd0, 3'd0, imm, imm, 1'b0, 1'b0, 1'b1, ac);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1);
  end

  initial begin
    int n, ready_bad;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_busy",      busy,      0);
    check("rst_out_data",  out_data,  0);
    check("rst_out_err",   out_err,   0);
    check("rst_in_ready",  in_ready,  1);
    rst = 1'b0;
    @(posedge clk); #1;

    // 1: ADD with carry-out and zero result
    ldi(3'd1, 8'hFF);
    ldi(3'd2, 8'h01);
    ex(4'd0, 3'd3, 3'd1, 3'd2, 8'h00, 1'b1, 1'b0);
    ex(4'd0, 3'd4, 3'd2, 3'd2, 8'h02, 1'b0, 1'b0);
    ex(4'd3, 3'd5, 3'd3, 3'd3, 8'h00, 1'b0, 1'b0);

    // 2: SUB back-to-back, borrow and no-borrow
    ldi(3'd1, 8'h05);
    ldi(3'd2, 8'h07);
    issue(4'd1, 3'd3, 3'd1, 3'd2, 8'h00, 8'hFE, 1'b0, 1'b0, 1'b1, c1);
    issue(4'd1, 3'd3, 3'd2, 3'd1, 8'h00, 8'h02, 1'b1, 1'b0, 1'b1, c2);
    check("sub_back_to_back_cycles", c2 - c1, 1);
    check("sub_latency_valid", out_valid, 1);

    // 3: logic, rotate, shift, compare
    ldi(3'd1, 8'h81);
    ex(4'd4, 3'd3, 3'd1, 3'd0, 8'h03, 1'b0, 1'b0);
    ldi(3'd2, 8'h84);
    ex(4'd5, 3'd3, 3'd0, 3'd2, 8'hC2, 1'b0, 1'b0);
    ldi(3'd1, 8'h5A);
    ldi(3'd2, 8'h5A);
    ex(4'd6, 3'd3, 3'd1, 3'd2, 8'h01, 1'b0, 1'b0);
    ldi(3'd1, 8'h80);
    ldi(3'd2, 8'h7F);
    ex(4'd7, 3'd3, 3'd1, 3'd2, 8'h01, 1'b0, 1'b0);
    ex(4'd7, 3'd3, 3'd2, 3'd1, 8'h00, 1'b0, 1'b0);
    ldi(3'd1, 8'hF0);
    ldi(3'd2, 8'h3C);
    ex(4'd2, 3'd3, 3'd1, 3'd2, 8'h30, 1'b0, 1'b0);
    ex(4'd3, 3'd3, 3'd1, 3'd2, 8'hFC, 1'b0, 1'b0);

    // 4: MUL timing and results
    ldi(3'd1, 8'h0D);
    ldi(3'd2, 8'h0B);
    ex(4'd9, 3'd3, 3'd1, 3'd2, 8'h8F, 1'b0, 1'b0);
    n = 0;
    ready_bad = 0;
    while (busy && n < 50) begin
      if (in_ready) ready_bad++;
      n++;
      @(posedge clk); #1;
    end
    check("mul_busy_cycles", n, 8);
    check("mul_in_ready_low", ready_bad, 0);
    ex(4'd3, 3'd4, 3'd3, 3'd3, 8'h8F, 1'b0, 1'b0);
    ldi(3'd1, 8'h20);
    ldi(3'd2, 8'h10);
    ex(4'd9, 3'd3, 3'd1, 3'd2, 8'h00, 1'b1, 1'b0);
    ldi(3'd1, 8'h03);
    ex(4'd9, 3'd1, 3'd1, 3'd1, 8'h09, 1'b0, 1'b0);
    ex(4'd3, 3'd4, 3'd1, 3'd1, 8'h09, 1'b0, 1'b0);

    // 5: output backpressure (r1=0x09, r2=0x10)
    @(posedge clk); #1;
    out_ready = 1'b0;
    ex(4'd0, 3'd3, 3'd1, 3'd2, 8'h19, 1'b0, 1'b0);
    in_op = 4'd8; in_rd = 3'd5; in_imm = 8'hAA; in_valid = 1'b1;
    sb.push_back('{8'hAA, 3'd5, 1'b0, 1'b0, 1'b0});
    for (int i = 0; i < 5; i++) begin
      check("stall_in_ready",  in_ready,  0);
      check("stall_out_valid", out_valid, 1);
      check("stall_out_data",  out_data,  8'h19);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    #1;
    check("resume_in_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    ex(4'd3, 3'd6, 3'd5, 3'd5, 8'hAA, 1'b0, 1'b0);

    // 6: reset aborts MUL, then an illegal opcode
    ldi(3'd1, 8'h03);
    ldi(3'd2, 8'h05);
    issue(4'd9, 3'd3, 3'd1, 3'd2, 8'h00, 8'h0F, 1'b0, 1'b0, 1'b0, ac);
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    #1;
    check("abort_busy",      busy,      0);
    check("abort_out_valid", out_valid, 0);
    check("abort_out_data",  out_data,  0);
    @(posedge clk); #1;
    rst = 1'b0;
    ex(4'hC, 3'd1, 3'd1, 3'd2, 8'h00, 1'b0, 1'b1);
    ex(4'd3, 3'd6, 3'd1, 3'd1, 8'h00, 1'b0, 1'b0);
    ex(4'd3, 3'd6, 3'd2, 3'd2, 8'h00, 1'b0, 1'b0);
    ex(4'd3, 3'd7, 3'd3, 3'd3, 8'h00, 1'b0, 1'b0);

    n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
